// File: rtl/apb_mem_slave_wait.sv
// apb_mem_slave_wait
//   APB4 slave that exposes a word-organised RAM. Each transfer has a setup
//   cycle, then WAIT_STATES cycles with PREADY low, then one completion cycle.
//   Byte-lane write strobes are supported. Misaligned accesses and accesses to
//   a word index at or beyond DEPTH are flagged on PSLVERR.
//
// Ports
//   PCLK     in   clock, rising edge
//   PRESETn  in   asynchronous active-low reset
//   PSEL     in   slave select
//   PENABLE  in   access phase qualifier
//   PWRITE   in   1=write, 0=read
//   PADDR    in   byte address [ADDR_WIDTH-1:0]
//   PWDATA   in   write data [DATA_WIDTH-1:0]
//   PSTRB    in   write byte strobes [DATA_WIDTH/8-1:0]
//   PRDATA   out  read data, non-zero only on an OKAY read completion
//   PREADY   out  transfer completes this cycle
//   PSLVERR  out  error response, only together with PREADY
module apb_mem_slave_wait #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [ADDR_WIDTH-1:0]     PADDR,
  input  logic [DATA_WIDTH-1:0]     PWDATA,
  input  logic [DATA_WIDTH/8-1:0]   PSTRB,
  output logic [DATA_WIDTH-1:0]     PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int ALIGN  = (STRB_W > 1) ? $clog2(STRB_W) : 0;
  localparam int IDX_W  = ADDR_WIDTH - ALIGN;
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_V  = (IDX_W + 1)'(DEPTH);
  localparam logic [3:0]     WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                err_reg, err_next;
  logic                write_reg, write_next;
  logic [RAM_AW-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] rd_word_reg;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [IDX_W-1:0]    index;
  logic [RAM_AW-1:0]   ram_addr;
  logic                misaligned;
  logic                decode_err;
  logic                setup;
  logic                commit;
  logic [STRB_W-1:0]   lane_we;

  // Address decode
  assign index    = PADDR[ADDR_WIDTH-1:ALIGN];
  assign ram_addr = index[RAM_AW-1:0];

  generate
    if (ALIGN > 0) begin : g_align
      assign misaligned = |PADDR[ALIGN-1:0];
    end else begin : g_noalign
      assign misaligned = 1'b0;
    end
  endgenerate

  assign decode_err = misaligned | ({1'b0, index} >= DEPTH_V);

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    write_next = write_reg;
    addr_next  = addr_reg;
    setup      = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        // PSEL & PENABLE without a preceding setup cycle is ignored.
        if (PSEL && !PENABLE) begin
          state_next = ACCESS;
          cnt_next   = WAIT_CNT;
          err_next   = decode_err;
          write_next = PWRITE;
          addr_next  = ram_addr;
          setup      = 1'b1;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          // Master abandoned the transfer: nothing is written.
          state_next = IDLE;
          cnt_next   = 4'd0;
          err_next   = 1'b0;
        end else if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          commit     = write_reg & ~err_reg;
          state_next = IDLE;
          err_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      err_reg   <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      write_reg <= write_next;
      addr_reg  <= addr_next;
    end
  end

  // Per-lane write enables for the completion edge.
  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
      assign lane_we[gi] = commit & PSTRB[gi];
    end
  endgenerate

  // RAM: no reset; read word captured on the setup edge of a read. Out of
  // range indices are never written and their read word is masked below.
  always_ff @(posedge PCLK) begin
    if (setup && !PWRITE) begin
      rd_word_reg <= mem[ram_addr];
    end
    for (int k = 0; k < STRB_W; k++) begin
      if (lane_we[k]) begin
        mem[addr_reg][k*8 +: 8] <= PWDATA[k*8 +: 8];
      end
    end
  end

  // Outputs come from registered state only.
  assign PREADY  = (state_reg == ACCESS) && (cnt_reg == 4'd0);
  assign PSLVERR = PREADY & err_reg;
  assign PRDATA  = (PREADY && !write_reg && !err_reg) ? rd_word_reg : '0;

endmodule

// File: tb/tb_apb_mem_slave_wait.sv
module tb_apb_mem_slave_wait;

  logic        clk = 1'b0;
  logic        presetn;
  logic        psel [3];
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instance 0: WAIT=0 DEPTH=64, instance 1: WAIT=3 DEPTH=64, instance 2: WAIT=0 DEPTH=48
  apb_mem_slave_wait #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(64), .WAIT_STATES(0)) u_w0 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_mem_slave_wait #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(64), .WAIT_STATES(3)) u_w3 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_mem_slave_wait #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(48), .WAIT_STATES(0)) u_d48 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  typedef struct {
    int          inst;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_waits;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int inst, bit wr, logic [7:0] addr, logic [31:0] wdata,
                              logic [3:0] strb, logic [31:0] exp_rd, logic exp_err, int exp_waits);
    vec_t v;
    v.inst = inst; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_waits = exp_waits;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One APB transfer; returns once the completion edge has passed (+1).
  // The next call may start its setup cycle immediately (back-to-back).
  task automatic xfer(input int inst, input bit wr, input logic [7:0] addr,
                      input logic [31:0] wd, input logic [3:0] strb,
                      output logic [31:0] rd, output logic err, output int waits);
    psel[inst] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    while (pready[inst] !== 1'b1 && waits <= 20) begin
      chk("wait_prdata", prdata[inst], 32'h0);
      chk("wait_pslverr", {31'h0, pslverr[inst]}, 32'h0);
      @(posedge clk); #1;
      waits++;
    end
    rd = prdata[inst];
    err = pslverr[inst];
    @(posedge clk); #1;
    psel[inst] = 1'b0; penable = 1'b0;
    chk("post_pready", {31'h0, pready[inst]}, 32'h0);
    $display("xfer inst=%0d %s addr=%h wdata=%h strb=%h rdata=%h err=%0b waits=%0d",
             inst, wr ? "W" : "R", addr, wd, strb, rd, err, waits);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          waits;

    presetn = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h0; pwdata = 32'h0; pstrb = 4'h0;
    for (int i = 0; i < 3; i++) psel[i] = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_pready", {31'h0, pready[i]}, 32'h0);
      chk("reset_pslverr", {31'h0, pslverr[i]}, 32'h0);
      chk("reset_prdata", prdata[i], 32'h0);
    end
    repeat (3) @(posedge clk);
    #1 presetn = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    vecs.push_back(mk(0, 1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(0, 0, 8'h10, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 0));
    vecs.push_back(mk(0, 1, 8'h10, 32'h00001234, 4'h3, 32'h0, 1'b0, 0));
    vecs.push_back(mk(0, 0, 8'h10, 32'h0,        4'h0, 32'hDEAD1234, 1'b0, 0));
    vecs.push_back(mk(0, 1, 8'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 0));
    vecs.push_back(mk(0, 0, 8'h10, 32'h0,        4'h0, 32'hDEAD1234, 1'b0, 0));
    vecs.push_back(mk(0, 1, 8'h14, 32'h11223344, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(0, 1, 8'h14, 32'hAA000000, 4'h8, 32'h0, 1'b0, 0));
    vecs.push_back(mk(0, 0, 8'h14, 32'h0,        4'h0, 32'hAA223344, 1'b0, 0));
    vecs.push_back(mk(0, 1, 8'hC0, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(0, 0, 8'hC0, 32'h0,        4'h0, 32'h0BADF00D, 1'b0, 0));
    vecs.push_back(mk(0, 1, 8'hFC, 32'h76543210, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(0, 0, 8'hFC, 32'h0,        4'h0, 32'h76543210, 1'b0, 0));
    vecs.push_back(mk(0, 0, 8'h11, 32'h0,        4'h0, 32'h0, 1'b1, 0));
    vecs.push_back(mk(2, 1, 8'h10, 32'h12345678, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(2, 1, 8'h11, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0));
    vecs.push_back(mk(2, 0, 8'h10, 32'h0,        4'h0, 32'h12345678, 1'b0, 0));
    vecs.push_back(mk(2, 1, 8'hC0, 32'h55555555, 4'hF, 32'h0, 1'b1, 0));
    vecs.push_back(mk(2, 0, 8'hC0, 32'h0,        4'h0, 32'h0, 1'b1, 0));
    vecs.push_back(mk(2, 0, 8'h11, 32'h0,        4'h0, 32'h0, 1'b1, 0));
    vecs.push_back(mk(2, 1, 8'hBC, 32'hCAFE0001, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(2, 0, 8'hBC, 32'h0,        4'h0, 32'hCAFE0001, 1'b0, 0));
    vecs.push_back(mk(1, 1, 8'h04, 32'h0000C0DE, 4'hF, 32'h0, 1'b0, 3));
    vecs.push_back(mk(1, 0, 8'h04, 32'h0,        4'h0, 32'h0000C0DE, 1'b0, 3));
    vecs.push_back(mk(1, 0, 8'h05, 32'h0,        4'h0, 32'h0, 1'b1, 3));

    foreach (vecs[i]) begin
      xfer(vecs[i].inst, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, err, waits);
      chk($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_pslverr", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
      chk($sformatf("vec%0d_waits", i), 32'(waits), 32'(vecs[i].exp_waits));
    end

    // Protocol error: PSEL & PENABLE in IDLE is ignored
    psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h10;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("idle_enable_pready", {31'h0, pready[0]}, 32'h0);
    end
    psel[0] = 1'b0; penable = 1'b0;
    @(posedge clk); #1;

    // Reset during a read completion cycle clears outputs asynchronously
    psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h10;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("pre_reset_pready", {31'h0, pready[0]}, 32'h1);
    chk("pre_reset_prdata", prdata[0], 32'hDEAD1234);
    presetn = 1'b0;
    #1;
    chk("async_reset_pready", {31'h0, pready[0]}, 32'h0);
    chk("async_reset_prdata", prdata[0], 32'h0);
    @(posedge clk); #1;
    psel[0] = 1'b0; penable = 1'b0;
    presetn = 1'b1;
    @(posedge clk); #1;

    // Reset mid-ACCESS of a write with WAIT_STATES=3: write must be dropped
    xfer(1, 1, 8'h08, 32'h11111111, 4'hF, rd, err, waits);
    chk("t1_prewrite_waits", 32'(waits), 32'd3);
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h22222222; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    presetn = 1'b0;
    #1;
    chk("t1_reset_pready", {31'h0, pready[1]}, 32'h0);
    chk("t1_reset_pslverr", {31'h0, pslverr[1]}, 32'h0);
    chk("t1_reset_prdata", prdata[1], 32'h0);
    repeat (5) @(posedge clk);
    #1;
    psel[1] = 1'b0; penable = 1'b0;
    presetn = 1'b1;
    @(posedge clk); #1;
    chk("t1_after_reset_pready", {31'h0, pready[1]}, 32'h0);
    xfer(1, 0, 8'h08, 32'h0, 4'h0, rd, err, waits);
    chk("t1_word_unchanged", rd, 32'h11111111);
    chk("t1_read_waits", 32'(waits), 32'd3);

    // Abort: PSEL dropped in the 2nd access cycle of a WAIT=3 write
    xfer(1, 1, 8'h0C, 32'h33333333, 4'hF, rd, err, waits);
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h44444444; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("t6_access1_pready", {31'h0, pready[1]}, 32'h0);
    @(posedge clk); #1;
    chk("t6_access2_pready", {31'h0, pready[1]}, 32'h0);
    psel[1] = 1'b0; penable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("t6_no_pready", {31'h0, pready[1]}, 32'h0);
    end
    xfer(1, 0, 8'h0C, 32'h0, 4'h0, rd, err, waits);
    chk("t6_word_unchanged", rd, 32'h33333333);
    chk("t6_next_err", {31'h0, err}, 32'h0);
    chk("t6_next_waits", 32'(waits), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
